ihex_wb_writer: RTL and testbench

Byte-to-word write packer between the Intel-HEX record decoder and the 32-bit Wishbone bus. It accepts decoded (byte address, data byte) pairs and merges bytes that fall in the same bus word into one word-wide write with the matching byte selects. It issues writes as a pipelined Wishbone master (stb/stall/ack/err) and tracks error and completion status for the loader.

---
 rtl/ihex_wb_writer.sv | 96 +++++++++
 tb/tb_ihex_wb_writer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ihex_wb_writer.sv
// ihex_wb_writer: packs decoded hex bytes into word-wide pipelined Wishbone writes
module ihex_wb_writer #(
  parameter int AW = 30,
  parameter int DW = 32,
  parameter int SELW = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [AW+1:0]   i_addr,
  input  logic [7:0]      i_data,
  input  logic            i_flush,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [SELW-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  output logic            o_busy,
  output logic            o_err,
  output logic [15:0]     o_words
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_nx;
  logic [AW-1:0] tag, word, pend_word;
  logic [DW-1:0] data;
  logic [SELW-1:0] mask, lane_bit, pend_bit;
  logic [1:0] lane, pend_lane;
  logic [7:0] pend_byte;
  logic pend_v, pend_flush, merge, fin, resp;
  assign lane = i_addr[1:0];
  assign word = i_addr[AW+1:2];
  assign lane_bit = SELW'(1) << lane;
  assign pend_bit = SELW'(1) << pend_lane;
  assign merge = mask == '0 || (word == tag && !mask[lane]);
  assign resp = i_wb_ack | i_wb_err;
  assign fin = (state == REQ && !i_wb_stall && resp) || (state == WAIT && resp);
  assign o_ready = state == IDLE && !i_reset;
  assign o_wb_cyc = state != IDLE;
  assign o_wb_stb = state == REQ;
  assign o_wb_we = o_wb_cyc;
  assign o_wb_addr = o_wb_cyc ? tag : '0;
  assign o_wb_data = o_wb_cyc ? data : '0;
  assign o_wb_sel = o_wb_cyc ? mask : '0;
  assign o_busy = o_wb_cyc || mask != '0;
  always_comb begin
    state_nx = state;
    if (state == IDLE)
      state_nx = (i_valid ? (!merge || &(mask | lane_bit) || i_flush) : (i_flush && mask != '0)) ? REQ : IDLE;
    else if (fin)
      state_nx = pend_v && pend_flush ? REQ : IDLE;
    else if (state == REQ && !i_wb_stall)
      state_nx = WAIT;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      tag <= '0;
      data <= '0;
      mask <= '0;
      pend_v <= 1'b0;
      pend_flush <= 1'b0;
      pend_byte <= '0;
      pend_word <= '0;
      pend_lane <= '0;
      o_err <= 1'b0;
      o_words <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && i_valid && merge) begin
        data[8*lane +: 8] <= i_data;
        mask <= mask | lane_bit;
        tag <= word;
      end
      if (state == IDLE && i_valid && !merge) begin
        pend_v <= 1'b1;
        pend_byte <= i_data;
        pend_word <= word;
        pend_lane <= lane;
        pend_flush <= i_flush;
      end
      if (fin) begin
        tag <= pend_v ? pend_word : '0;
        mask <= pend_v ? pend_bit : '0;
        data <= pend_v ? DW'(pend_byte) << (8*pend_lane) : '0;
        pend_v <= 1'b0;
        o_err <= o_err | i_wb_err;
        o_words <= o_words + 16'(!i_wb_err);
      end
    end
  end
endmodule

// File: tb/tb_ihex_wb_writer.sv
// tb_ihex_wb_writer: table and scoreboard driven check of the hex byte-to-word packer
module tb_ihex_wb_writer;
  logic i_clk = 1'b0;
  logic i_reset, i_valid, i_flush, i_wb_stall, i_wb_ack, i_wb_err;
  logic [31:0] i_addr;
  logic [7:0] i_data;
  logic o_ready, o_wb_cyc, o_wb_stb, o_wb_we, o_busy, o_err;
  logic [29:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0] o_wb_sel;
  logic [15:0] o_words;
  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0] sel;
  } wr_t;
  typedef struct {
    logic v;
    logic [31:0] addr;
    logic [7:0] data;
    logic flush;
    logic push;
    logic [29:0] eaddr;
    logic [31:0] edata;
    logic [3:0] esel;
  } vec_t;
  wr_t exp_q[$];
  vec_t tbl[8];
  int n_cmp = 0, n_bad = 0, stall_cfg = 0, sl_cnt = 0, exp_words = 0;
  bit ack_same = 1, err_cfg = 0, resp_en = 1, force_ack = 0, sl_seen = 0, sl_pend = 0;

  ihex_wb_writer dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_addr(i_addr), .i_data(i_data), .i_flush(i_flush),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .o_busy(o_busy), .o_err(o_err), .o_words(o_words)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic respond();
    if (err_cfg) i_wb_err = 1'b1;
    else i_wb_ack = 1'b1;
  endtask

  initial begin
    wr_t w;
    i_wb_stall = 1'b0;
    i_wb_ack = 1'b0;
    i_wb_err = 1'b0;
    forever begin
      @(negedge i_clk);
      i_wb_stall = 1'b0;
      i_wb_ack = force_ack;
      i_wb_err = 1'b0;
      if (i_reset || !o_wb_cyc) begin
        sl_seen = 0;
        sl_pend = 0;
      end else if (o_wb_stb) begin
        if (!sl_seen) begin
          sl_seen = 1;
          sl_cnt = stall_cfg;
        end
        if (sl_cnt > 0) begin
          i_wb_stall = 1'b1;
          sl_cnt--;
        end else begin
          sl_seen = 0;
          chk("wr_expected", 64'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk("wr_addr", 64'(o_wb_addr), 64'(w.addr));
            chk("wr_data", 64'(o_wb_data), 64'(w.data));
            chk("wr_sel", 64'(o_wb_sel), 64'(w.sel));
          end
          if (resp_en) begin
            if (ack_same) respond();
            else sl_pend = 1;
          end
        end
      end else if (sl_pend) begin
        respond();
        sl_pend = 0;
      end
    end
  end

  task automatic send(input logic v, input logic [31:0] a, input logic [7:0] d, input logic f);
    int n = 0;
    @(negedge i_clk);
    i_valid = v;
    i_addr = a;
    i_data = d;
    i_flush = f;
    while (!o_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    chk("ready_timeout", 64'(n < 100), 1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] base, input logic [7:0] b0);
    wr_t w;
    w.addr = base[31:2];
    w.data = {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
    w.sel = 4'hF;
    exp_q.push_back(w);
    for (int k = 0; k < 4; k++) send(1'b1, base + 32'(k), b0 + 8'(k), 1'b0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((o_busy || o_wb_cyc) && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    chk("idle_timeout", 64'(n < 50), 1);
  endtask

  initial begin
    wr_t w;
    int c, r, sc, bad;
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    i_addr = '0;
    i_data = '0;
    repeat (2) @(negedge i_clk);
    chk("rst_cyc_stb_we", 64'({o_wb_cyc, o_wb_stb, o_wb_we}), 0);
    chk("rst_addr", 64'(o_wb_addr), 0);
    chk("rst_data", 64'(o_wb_data), 0);
    chk("rst_sel", 64'(o_wb_sel), 0);
    chk("rst_ready", 64'(o_ready), 0);
    chk("rst_busy", 64'(o_busy), 0);
    chk("rst_err", 64'(o_err), 0);
    chk("rst_words", 64'(o_words), 0);
    i_reset = 1'b0;
    tbl[0] = '{1, 32'h100, 8'h11, 0, 0, 30'h0, 32'h0, 4'h0};
    tbl[1] = '{1, 32'h101, 8'h22, 0, 0, 30'h0, 32'h0, 4'h0};
    tbl[2] = '{1, 32'h102, 8'h33, 0, 0, 30'h0, 32'h0, 4'h0};
    tbl[3] = '{1, 32'h103, 8'h44, 0, 1, 30'h40, 32'h44332211, 4'hF};
    tbl[4] = '{1, 32'h100, 8'hAA, 0, 0, 30'h0, 32'h0, 4'h0};
    tbl[5] = '{1, 32'h101, 8'hBB, 0, 0, 30'h0, 32'h0, 4'h0};
    tbl[6] = '{1, 32'h208, 8'hCC, 0, 1, 30'h40, 32'h0000BBAA, 4'h3};
    tbl[7] = '{0, 32'h0, 8'h00, 1, 1, 30'h82, 32'h000000CC, 4'h1};
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].push) begin
        w.addr = tbl[i].eaddr;
        w.data = tbl[i].edata;
        w.sel = tbl[i].esel;
        exp_q.push_back(w);
      end
      send(tbl[i].v, tbl[i].addr, tbl[i].data, tbl[i].flush);
      if (i == 3) begin
        @(negedge i_clk);
        chk("full_cyc_stb", 64'({o_wb_cyc, o_wb_stb}), 2'b11);
        @(negedge i_clk);
        chk("full_cyc_ready", 64'({o_wb_cyc, o_ready}), 2'b01);
        wait_idle();
        exp_words = 1;
        chk("full_words", 64'(o_words), 64'(exp_words));
        chk("full_busy", 64'(o_busy), 0);
      end
    end
    wait_idle();
    exp_words = 3;
    chk("conflict_words", 64'(o_words), 64'(exp_words));
    w = '{30'h40, 32'h11, 4'h1};
    exp_q.push_back(w);
    w = '{30'h40, 32'h55, 4'h1};
    exp_q.push_back(w);
    send(1'b1, 32'h100, 8'h11, 1'b0);
    send(1'b1, 32'h100, 8'h55, 1'b1);
    c = 0;
    r = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge i_clk);
      if (!o_wb_cyc) break;
      c++;
      if (o_ready) r++;
    end
    chk("collide_cyc_cycles", 64'(c), 2);
    chk("collide_ready_cycles", 64'(r), 0);
    wait_idle();
    exp_words = 5;
    chk("collide_words", 64'(o_words), 64'(exp_words));
    stall_cfg = 3;
    send_word(32'h40, 8'h01);
    sc = 0;
    bad = 0;
    r = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge i_clk);
      if (o_wb_stb) begin
        sc++;
        if (o_wb_addr != 30'h10 || o_wb_data != 32'h04030201 || o_wb_sel != 4'hF) bad++;
      end
      if (o_wb_cyc && o_ready) r++;
    end
    stall_cfg = 0;
    chk("stall_stb_cycles", 64'(sc), 4);
    chk("stall_unstable", 64'(bad), 0);
    chk("stall_ready", 64'(r), 0);
    wait_idle();
    exp_words = 6;
    chk("stall_words", 64'(o_words), 64'(exp_words));
    err_cfg = 1;
    send_word(32'h80, 8'hA0);
    wait_idle();
    err_cfg = 0;
    chk("err_flag", 64'(o_err), 1);
    chk("err_words", 64'(o_words), 64'(exp_words));
    send_word(32'h84, 8'hB0);
    wait_idle();
    exp_words = 7;
    chk("after_err_words", 64'(o_words), 64'(exp_words));
    chk("after_err_flag", 64'(o_err), 1);
    resp_en = 0;
    send_word(32'hC0, 8'hC0);
    @(negedge i_clk);
    @(negedge i_clk);
    chk("rstmid_wait", 64'({o_wb_cyc, o_wb_stb}), 2'b10);
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("rstmid_cyc", 64'(o_wb_cyc), 0);
    chk("rstmid_words", 64'(o_words), 0);
    chk("rstmid_err", 64'(o_err), 0);
    chk("rstmid_busy", 64'(o_busy), 0);
    chk("rstmid_ready", 64'(o_ready), 0);
    i_reset = 1'b0;
    resp_en = 1;
    force_ack = 1;
    repeat (2) @(negedge i_clk);
    force_ack = 0;
    @(negedge i_clk);
    chk("late_ack_words", 64'(o_words), 0);
    chk("late_ack_cyc_busy", 64'({o_wb_cyc, o_busy}), 0);
    send_word(32'h200, 8'hD0);
    wait_idle();
    chk("recover_words", 64'(o_words), 1);
    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
